// File: rtl/seg_display_driver.sv
// Seven-segment display endpoint: latches a 32-bit CPU write and scans it as
// eight hex digits onto a common-anode, time-multiplexed display.
module seg_display_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SEG_WE,
    input  logic [31:0] SEG_WD,
    output logic [7:0]  AN,
    output logic [7:0]  SEG
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

    logic [31:0]   v_q, v_d;
    logic [CW-1:0] c_q, c_d;
    logic [2:0]    d_q, d_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    nibble;

    // Write path and scan counter; a write and a digit advance can share an edge.
    always_comb begin
        v_d = v_q;
        c_d = c_q + 1'b1;
        d_d = d_q;
        if (SEG_WE) begin
            v_d = SEG_WD;
        end
        if (c_q == C_LAST) begin
            c_d = '0;
            d_d = d_q + 3'd1;
        end
    end

    // Outputs are built from the registered digit index and value, one cycle behind.
    always_comb begin
        nibble = v_q[{d_q, 2'b00} +: 4];
        an_d   = 8'hFF;
        an_d[d_q] = 1'b0;
        case (nibble)
            4'h0:    seg_d = 8'hC0;
            4'h1:    seg_d = 8'hF9;
            4'h2:    seg_d = 8'hA4;
            4'h3:    seg_d = 8'hB0;
            4'h4:    seg_d = 8'h99;
            4'h5:    seg_d = 8'h92;
            4'h6:    seg_d = 8'h82;
            4'h7:    seg_d = 8'hF8;
            4'h8:    seg_d = 8'h80;
            4'h9:    seg_d = 8'h90;
            4'hA:    seg_d = 8'h88;
            4'hB:    seg_d = 8'h83;
            4'hC:    seg_d = 8'hC6;
            4'hD:    seg_d = 8'hA1;
            4'hE:    seg_d = 8'h86;
            default: seg_d = 8'h8E;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            d_q   <= d_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized bench for seg_display_driver: a cycle-count reference model predicts
// the lit digit and its segment pattern for every clock edge.
module tb_seg_display_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seg_we = 1'b0;
    logic [31:0] seg_wd = '0;
    logic [7:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  hex_tbl[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: edges seen since reset release, and the latched value.
    int unsigned t_m;
    logic [31:0] v_m;

    seg_display_driver #(.SCAN_DIV(SD)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .SEG_WE(seg_we),
        .SEG_WD(seg_wd),
        .AN    (an),
        .SEG   (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_digit();
        return int'((t_m / SD) % 8);
    endfunction

    // One clock: drive inputs, predict the next edge's outputs, check at negedge.
    task automatic drive_cycle(input logic we, input logic [31:0] wd);
        int d;
        logic [7:0] an_e;
        logic [3:0] nib;
        seg_we = we;
        seg_wd = wd;
        d = model_digit();
        an_e = 8'hFF;
        an_e[d] = 1'b0;
        nib = v_m[4*d +: 4];
        exp_q.push_back({an_e, hex_tbl[nib]});
        @(posedge clk);
        t_m++;
        if (we) v_m = wd;
        @(negedge clk);
        check("an_seg", {an, seg}, exp_q.pop_front());
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t_m = 0;
        v_m = '0;
    endtask

    task automatic run_until_digit(input int dig);
        int guard;
        guard = 0;
        while (model_digit() != dig && guard < 8 * SD) begin
            drive_cycle(1'b0, $urandom);
            guard++;
        end
    endtask

    initial begin
        t_m = 0;
        v_m = '0;
        repeat (2) @(negedge clk);
        check("reset_hold", {an, seg}, 16'hFFFF);
        release_reset();

        // Idle frame with SEG_WD wiggling but no strobe.
        repeat (8 * SD + 4) drive_cycle(1'b0, $urandom);

        // Full hex decode across a frame.
        run_until_digit(0);
        drive_cycle(1'b1, 32'h89AB_CDEF);
        repeat (8 * SD + 2) drive_cycle(1'b0, $urandom);

        // Write latency while digit 2 is scanned.
        drive_cycle(1'b1, 32'h0);
        run_until_digit(2);
        drive_cycle(1'b1, 32'h0000_0500);
        drive_cycle(1'b0, $urandom);
        check("latency_pin", {an, seg}, 16'hFB92);

        // Back-to-back writes, then hold.
        drive_cycle(1'b1, 32'h1111_1111);
        drive_cycle(1'b1, 32'h2222_2222);
        repeat (8 * SD + 2) drive_cycle(1'b0, $urandom);
        check("b2b_last_wins", {8'h00, seg}, 16'h00A4);

        // Write landing on the 3 -> 4 digit advance.
        while ((t_m % (8 * SD)) != (4 * SD - 1)) drive_cycle(1'b0, $urandom);
        drive_cycle(1'b1, 32'h0007_0000);
        drive_cycle(1'b0, $urandom);
        check("adv_write", {an, seg}, 16'hEFF8);

        // Reset mid-scan on digit 5 with all-F value.
        drive_cycle(1'b1, 32'hFFFF_FFFF);
        run_until_digit(5);
        drive_cycle(1'b0, $urandom);
        drive_cycle(1'b0, $urandom);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {an, seg}, 16'hFFFF);
        @(posedge clk);
        #1 check("reset_no_clk_effect", {an, seg}, 16'hFFFF);
        release_reset();
        repeat (8 * SD + 1) drive_cycle(1'b0, $urandom);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive_cycle($urandom_range(0, 3) == 0, $urandom);
        end

        // Reset asserted while a write is pending.
        seg_we = 1'b1;
        seg_wd = $urandom;
        #2 rst_n = 1'b0;
        #1 check("reset_mid_write", {an, seg}, 16'hFFFF);
        release_reset();
        repeat (8 * SD) drive_cycle(1'b0, $urandom);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
